// File: rtl/result_rx.sv
`default_nettype none
// ============================================================================
//  Module   : result_rx
//  Purpose  : Serial result receiver for the systolic-array accelerator.
//             Deserializes the 8N1 UART stream from the array's tx line.
//             Packs three bytes, little-endian, into one 24-bit PE result.
//             Stores up to NUM_RESULTS results in a buffer that is read back
//             through a registered read port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock, rising edge
//    reset      in   asynchronous, active-high reset
//    rx         in   serial line, idle high, asynchronous to clk
//    word_valid out  one-cycle pulse when a 24-bit result completes
//    word_data  out  last assembled result (held)
//    word_index out  buffer index of word_data
//    frame_err  out  sticky bad-stop-bit flag
//    rx_done    out  sticky; NUM_RESULTS words stored
//    rd_addr    in   buffer read address
//    rd_data    out  buffer contents at rd_addr, one cycle later
// ============================================================================
module result_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_RESULTS  = 64,
  parameter int AW           = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          word_valid,
  output logic [23:0]   word_data,
  output logic [AW-1:0] word_index,
  output logic          frame_err,
  output logic          rx_done,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] c_HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] c_FULL_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   c_NUM       = (AW + 1)'(NUM_RESULTS);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  logic [1:0]    r_sync;
  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bitc;
  logic [7:0]    r_shift;
  logic [1:0]    r_byte_cnt;
  logic [15:0]   r_lo;
  // One extra bit so the index can reach NUM_RESULTS without wrapping.
  logic [AW:0]   r_wr_idx;
  logic          r_word_valid;
  logic [23:0]   r_word_data;
  logic [AW-1:0] r_word_index;
  logic          r_frame_err;
  logic          r_rx_done;
  logic [23:0]   r_rd_data;
  logic [23:0]   r_buf [0:(1<<AW)-1];

  logic          w_rxs;
  logic          w_stop_tick;
  logic          w_store;
  logic [AW:0]   w_wr_next;

  assign w_rxs       = r_sync[1];
  assign w_stop_tick = (r_state == c_ST_STOP) && (r_baud == c_FULL_LAST);
  // A good stop bit on the third byte of a word, while still collecting.
  assign w_store     = w_stop_tick && w_rxs && !r_rx_done && (r_byte_cnt == 2'd2);
  assign w_wr_next   = r_wr_idx + 1'b1;

  // Two-flop synchronizer; flops reset to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_ST_IDLE;
      r_baud       <= '0;
      r_bitc       <= '0;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_lo         <= '0;
      r_wr_idx     <= '0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_index <= '0;
      r_frame_err  <= 1'b0;
      r_rx_done    <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          r_baud <= '0;
          r_bitc <= '0;
          if (!w_rxs) r_state <= c_ST_START;
        end
        c_ST_START: begin
          if (r_baud == c_HALF_LAST) begin
            r_baud  <= '0;
            // Line back high at mid start bit: treat as a glitch.
            r_state <= w_rxs ? c_ST_IDLE : c_ST_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        c_ST_DATA: begin
          if (r_baud == c_FULL_LAST) begin
            r_baud  <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            r_bitc  <= r_bitc + 1'b1;
            if (r_bitc == 3'd7) r_state <= c_ST_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        c_ST_STOP: begin
          if (w_stop_tick) begin
            r_baud  <= '0;
            r_state <= c_ST_IDLE;
            if (!w_rxs) begin
              // Bad framing: drop the byte and any partial word.
              r_frame_err <= 1'b1;
              r_byte_cnt  <= '0;
            end else if (!r_rx_done) begin
              case (r_byte_cnt)
                2'd0: begin
                  r_lo[7:0]  <= r_shift;
                  r_byte_cnt <= 2'd1;
                end
                2'd1: begin
                  r_lo[15:8] <= r_shift;
                  r_byte_cnt <= 2'd2;
                end
                default: begin
                  r_byte_cnt   <= 2'd0;
                  r_word_data  <= {r_shift, r_lo};
                  r_word_index <= r_wr_idx[AW-1:0];
                  r_word_valid <= 1'b1;
                  r_wr_idx     <= w_wr_next;
                  if (w_wr_next == c_NUM) r_rx_done <= 1'b1;
                end
              endcase
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Result storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_store) r_buf[r_wr_idx[AW-1:0]] <= {r_shift, r_lo};
  end

  // Registered read; a same-cycle write to rd_addr returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_buf[rd_addr];
  end

  assign word_valid = r_word_valid;
  assign word_data  = r_word_data;
  assign word_index = r_word_index;
  assign frame_err  = r_frame_err;
  assign rx_done    = r_rx_done;
  assign rd_data    = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_result_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_rx
//  Purpose  : Self-checking bench for result_rx. Expected words are queued
//             as stimulus is sent and compared when word_valid pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_rx;

  localparam int CPB = 16;
  localparam int NUM = 64;
  localparam int AW  = 6;

  typedef struct {
    logic [23:0]   d;
    logic [AW-1:0] i;
    logic          dn;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          rx;
  logic          word_valid;
  logic [23:0]   word_data;
  logic [AW-1:0] word_index;
  logic          frame_err;
  logic          rx_done;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_words   = 0;
  int   exp_words = 0;

  result_rx #(.CLKS_PER_BIT(CPB), .NUM_RESULTS(NUM), .AW(AW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_index (word_index),
    .frame_err  (frame_err),
    .rx_done    (rx_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!reset && word_valid === 1'b1) begin
      n_words++;
      if (sb.size() == 0) begin
        chk("unexpected_word_valid", {31'd0, word_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word_data",  {8'd0, word_data},   {8'd0, e.d});
        chk("word_index", {26'd0, word_index}, {26'd0, e.i});
        chk("rx_done",    {31'd0, rx_done},    {31'd0, e.dn});
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int idle_bits);
    hold(1'b0, CPB);
    for (int k = 0; k < 8; k++) hold(b[k], CPB);
    hold(stop_ok, CPB);
    if (idle_bits > 0) hold(1'b1, idle_bits * CPB);
    else rx = 1'b1;
  endtask

  // Sends one 3-byte word back-to-back; optionally queues the expected result.
  task automatic send_word(input logic [23:0] w, input int idx, input bit expect_it);
    if (expect_it) begin
      exp_t e;
      e.d  = w;
      e.i  = AW'(idx);
      e.dn = (idx == NUM - 1);
      sb.push_back(e);
      exp_words++;
    end
    send_byte(w[7:0],   1'b1, 0);
    send_byte(w[15:8],  1'b1, 0);
    send_byte(w[23:16], 1'b1, 1);
  endtask

  task automatic read_chk(input int addr, input logic [23:0] exp);
    rd_addr = AW'(addr);
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", addr), {8'd0, rd_data}, {8'd0, exp});
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    rd_addr = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word_data",  {8'd0, word_data},   32'd0);
    chk("rst_word_index", {26'd0, word_index}, 32'd0);
    chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
    chk("rst_rx_done",    {31'd0, rx_done},    32'd0);
    chk("rst_rd_data",    {8'd0, rd_data},     32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Basic word.
    send_word(24'hABCDEF, 0, 1'b1);
    chk("sb_drain_basic", sb.size(), 0);
    chk("frame_err_basic", {31'd0, frame_err}, 32'd0);
    chk("count_basic", n_words, exp_words);
    read_chk(0, 24'hABCDEF);

    // Start-bit glitch; next word still starts at byte 0.
    hold(1'b0, 4);
    hold(1'b1, 3 * CPB);
    chk("count_glitch", n_words, exp_words);
    send_word(24'h654321, 1, 1'b1);
    chk("sb_drain_glitch", sb.size(), 0);

    // Partial word, then a bad stop bit drops it.
    send_byte(8'hAA, 1'b1, 1);
    send_byte(8'h11, 1'b0, 2);
    chk("frame_err_set", {31'd0, frame_err}, 32'd1);
    send_word(24'h030201, 2, 1'b1);
    chk("sb_drain_ferr", sb.size(), 0);
    chk("frame_err_sticky", {31'd0, frame_err}, 32'd1);
    read_chk(2, 24'h030201);

    // Fill the buffer from a clean state.
    pulse_reset();
    chk("frame_err_clr", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < NUM; i++) begin
      if (i == NUM - 1) chk("rx_done_before_last", {31'd0, rx_done}, 32'd0);
      send_word(24'(i) * 24'h010101, i, 1'b1);
    end
    chk("sb_drain_fill", sb.size(), 0);
    chk("rx_done_set", {31'd0, rx_done}, 32'd1);
    send_word(24'h777777, NUM, 1'b0);
    chk("count_no_65th", n_words, exp_words);
    for (int i = 0; i < NUM; i++) read_chk(i, 24'(i) * 24'h010101);

    // Reset mid-DATA of byte 1 must clear outputs without a clock edge.
    send_byte(8'h5A, 1'b1, 0);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    #2;
    reset = 1'b1;
    #1;
    chk("async_word_valid", {31'd0, word_valid}, 32'd0);
    chk("async_word_data",  {8'd0, word_data},   32'd0);
    chk("async_word_index", {26'd0, word_index}, 32'd0);
    chk("async_frame_err",  {31'd0, frame_err},  32'd0);
    chk("async_rx_done",    {31'd0, rx_done},    32'd0);
    chk("async_rd_data",    {8'd0, rd_data},     32'd0);
    rx = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_word(24'h123456, 0, 1'b1);
    chk("sb_drain_after_rst", sb.size(), 0);
    read_chk(0, 24'h123456);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
